// File: rtl/ysyx_25040101_alu_arb.sv
// ysyx_25040101_alu_arb
//
// Two-requester arbiter in front of one shared, purely combinational ALU.
// One operation is in flight at a time and passes through three states:
//   StIdle : grant one pending requester and capture its op/operands/owner.
//   StExec : the shared ALU sees the captured operands; its result is registered.
//   StResp : the result is offered to the owner until it is taken.
// An operation takes at least three cycles: accept, execute, respond.
//
// Ports
//   clk_i, rst_i               clock; synchronous active-high reset
//   reqN_valid_i/ready_o       request handshake for requester N (N = 0, 1)
//   reqN_op_i                  00 add, 01 sub, 10 or, 11 and
//   reqN_srca_i/srcb_i         operands
//   rspN_valid_o/ready_i       response handshake for requester N
//   rspN_result_o              result (both requesters see the result register)
//   alu_srca_o/srcb_o/ctrl_o   operands and op select driven to the shared ALU
//   alu_result_i               combinational result from the shared ALU
//
// Configuration
//   YSYX_25040101_ALU_ARB_FIXED_PRIO_EN : when defined, req0 always wins a tie
//   and no grant history is kept. When undefined, ties are resolved round robin.

module ysyx_25040101_alu_arb #(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [1:0]          req0_op_i,
  input  logic [DATA_LEN-1:0] req0_srca_i,
  input  logic [DATA_LEN-1:0] req0_srcb_i,

  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [1:0]          req1_op_i,
  input  logic [DATA_LEN-1:0] req1_srca_i,
  input  logic [DATA_LEN-1:0] req1_srcb_i,

  output logic                rsp0_valid_o,
  input  logic                rsp0_ready_i,
  output logic [DATA_LEN-1:0] rsp0_result_o,

  output logic                rsp1_valid_o,
  input  logic                rsp1_ready_i,
  output logic [DATA_LEN-1:0] rsp1_result_o,

  output logic [DATA_LEN-1:0] alu_srca_o,
  output logic [DATA_LEN-1:0] alu_srcb_o,
  output logic [1:0]          alu_ctrl_o,
  input  logic [DATA_LEN-1:0] alu_result_i
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Captured operation and its owner
  logic [1:0]          op_q;
  logic [DATA_LEN-1:0] srca_q;
  logic [DATA_LEN-1:0] srcb_q;
  logic [DATA_LEN-1:0] result_q;
  logic                owner_q;

`ifndef YSYX_25040101_ALU_ARB_FIXED_PRIO_EN
  // Requester granted by the most recent accept; the other one wins the next tie
  logic                last_grant_q;
`endif

  logic grant;   // requester that would be served if the FSM is in StIdle
  logic accept;  // request handshake this cycle
  logic rsp_hs;  // response handshake with the owner this cycle

  // ---------------------------------------------------------------------------
  // Grant selection (only meaningful while idle; gated by the state below)
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef YSYX_25040101_ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant_q;
`endif
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = StResp;
      StResp: if (rsp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    rsp_hs       = 1'b0;
    unique case (state_q)
      StIdle: begin
        req0_ready_o = req0_valid_i && (grant == 1'b0);
        req1_ready_o = req1_valid_i && (grant == 1'b1);
      end
      StResp: begin
        rsp0_valid_o = (owner_q == 1'b0);
        rsp1_valid_o = (owner_q == 1'b1);
        // A non-owner's ready is ignored because its valid is low
        rsp_hs       = (rsp0_valid_o && rsp0_ready_i) || (rsp1_valid_o && rsp1_ready_i);
      end
      default: ;
    endcase
  end

  assign accept = req0_ready_o || req1_ready_o;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= 2'b00;
      srca_q   <= '0;
      srcb_q   <= '0;
      result_q <= '0;
      owner_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= grant ? req1_op_i   : req0_op_i;
        srca_q  <= grant ? req1_srca_i : req0_srca_i;
        srcb_q  <= grant ? req1_srcb_i : req0_srcb_i;
        owner_q <= grant;
      end
      if (state_q == StExec) begin
        result_q <= alu_result_i;
      end
    end
  end

`ifndef YSYX_25040101_ALU_ARB_FIXED_PRIO_EN
  // Reset value 1 makes req0 win the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= grant;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Shared ALU and response outputs come straight from registers
  // ---------------------------------------------------------------------------
  assign alu_srca_o    = srca_q;
  assign alu_srcb_o    = srcb_q;
  assign alu_ctrl_o    = op_q;
  assign rsp0_result_o = result_q;
  assign rsp1_result_o = result_q;

endmodule

// File: tb/tb_ysyx_25040101_alu_arb.sv
// Self-checking bench for ysyx_25040101_alu_arb. Provides the shared ALU as a
// combinational model, drives requests from tasks and checks responses against
// a queue of expected {owner, result} entries pushed at each accept.

module tb_ysyx_25040101_alu_arb;

  localparam int unsigned DL = 32;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]    req0_op, req1_op;
  logic [DL-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DL-1:0] rsp0_result, rsp1_result;
  logic [DL-1:0] alu_srca, alu_srcb, alu_result;
  logic [1:0]    alu_ctrl;

  typedef struct packed {
    logic          owner;
    logic [DL-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  logic exp_last;  // model of the grant history (round robin)

  ysyx_25040101_alu_arb #(.DATA_LEN(DL)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_op_i    (req0_op),
    .req0_srca_i  (req0_srca),
    .req0_srcb_i  (req0_srcb),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_op_i    (req1_op),
    .req1_srca_i  (req1_srca),
    .req1_srcb_i  (req1_srcb),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_ready_i (rsp0_ready),
    .rsp0_result_o(rsp0_result),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_ready_i (rsp1_ready),
    .rsp1_result_o(rsp1_result),
    .alu_srca_o   (alu_srca),
    .alu_srcb_o   (alu_srcb),
    .alu_ctrl_o   (alu_ctrl),
    .alu_result_i (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DL-1:0] ref_alu(input logic [1:0] op, input logic [DL-1:0] a,
                                            input logic [DL-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a | b;
      default: return a & b;
    endcase
  endfunction

  // Shared ALU
  always_comb alu_result = ref_alu(alu_ctrl, alu_srca, alu_srcb);

  function automatic logic tie_grant(input logic last);
`ifdef YSYX_25040101_ALU_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return ~last;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_op = 2'b00; req0_srca = '0; req0_srcb = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_srca = '0; req1_srcb = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if (alu_srca !== '0 || alu_srcb !== '0 || alu_ctrl !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_alu: got srca=%h srcb=%h ctrl=%b, want all 0", alu_srca, alu_srcb,
               alu_ctrl);
    end
    n_tests++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp_valid: got %b%b, want 00", rsp0_valid, rsp1_valid);
    end
    n_tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_idle: got %b%b, want 00", req0_ready, req1_ready);
    end
    // A request during reset is visible as ready (IDLE) but must not be captured
    req0_valid = 1'b1; req0_op = 2'b10; req0_srca = 32'h1234; req0_srcb = 32'h5678;
    @(negedge clk);
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_grant: got %b%b, want 10", req0_ready, req1_ready);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    exp_last = 1'b1;
    sb.delete();
    @(negedge clk);
    n_tests++;
    if (alu_srca !== '0 || alu_ctrl !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_priority: got srca=%h ctrl=%b, want 0", alu_srca, alu_ctrl);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority_rsp: got %b%b, want 00", rsp0_valid, rsp1_valid);
    end
    tick();
  endtask

  task automatic test_add_wrap();
    exp_t e;
    req0_valid = 1'b1; req0_op = 2'b00; req0_srca = 32'h7FFF_FFFF; req0_srcb = 32'h0000_0001;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL add_accept: got ready=%b%b, want 10", req0_ready, req1_ready);
    end
    sb.push_back({1'b0, ref_alu(req0_op, req0_srca, req0_srcb)});
    exp_last = 1'b0;
    tick();
    // Payload is only sampled in the handshake cycle
    req0_valid = 1'b0; req0_srca = $urandom(); req0_srcb = $urandom(); req0_op = 2'b11;
    @(negedge clk);
    n_tests++;
    if (rsp0_valid !== 1'b0 || alu_srca !== 32'h7FFF_FFFF || alu_srcb !== 32'h1 ||
        alu_ctrl !== 2'b00) begin
      n_fail++;
      $display("FAIL add_exec: got valid=%b srca=%h srcb=%h ctrl=%b, want 0 7fffffff 1 00",
               rsp0_valid, alu_srca, alu_srcb, alu_ctrl);
    end
    tick();
    @(negedge clk);
    if (sb.size() == 0) e = '0; else e = sb.pop_front();
    n_tests++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_result !== e.res ||
        rsp1_result !== e.res || e.res !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL add_resp: got valid=%b%b r0=%h r1=%h, want 10 %h", rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, e.res);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done: got valid=%b%b, want 00", rsp0_valid, rsp1_valid);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_sub_then_next();
    exp_t e;
    req1_valid = 1'b1; req1_op = 2'b01; req1_srca = 32'h5; req1_srcb = 32'h7;
    rsp1_ready = 1'b1; rsp0_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_accept: got ready=%b%b, want 01", req0_ready, req1_ready);
    end
    sb.push_back({1'b1, ref_alu(req1_op, req1_srca, req1_srcb)});
    exp_last = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    // New request from req0 arrives during the response handshake cycle
    req0_valid = 1'b1; req0_op = 2'b10; req0_srca = 32'hA0; req0_srcb = 32'h05;
    @(negedge clk);
    if (sb.size() == 0) e = '0; else e = sb.pop_front();
    n_tests++;
    if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_result !== e.res ||
        e.res !== 32'hFFFF_FFFE || !e.owner) begin
      n_fail++;
      $display("FAIL sub_resp: got valid=%b%b r1=%h, want 01 %h", rsp0_valid, rsp1_valid,
               rsp1_result, e.res);
    end
    n_tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_no_accept_in_hs: got ready=%b%b, want 00", req0_ready, req1_ready);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL next_accept: got ready0=%b, want 1", req0_ready);
    end
    sb.push_back({1'b0, ref_alu(req0_op, req0_srca, req0_srcb)});
    exp_last = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    @(negedge clk);
    if (sb.size() == 0) e = '0; else e = sb.pop_front();
    n_tests++;
    if (rsp0_valid !== 1'b1 || rsp0_result !== e.res) begin
      n_fail++;
      $display("FAIL next_resp: got valid=%b r0=%h, want 1 %h", rsp0_valid, rsp0_result, e.res);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic g;
    logic [2:0] seen;
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    exp_last = 1'b1;
    sb.delete();
    seen = 3'b000;
    req0_valid = 1'b1; req0_op = 2'b10; req0_srca = 32'hF0F0_F0F0; req0_srcb = 32'h0F0F_0F0F;
    req1_valid = 1'b1; req1_op = 2'b11; req1_srca = 32'hFFFF_0000; req1_srcb = 32'h00FF_FF00;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      g = tie_grant(exp_last);
      n_tests++;
      if (req0_ready !== ~g || req1_ready !== g) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got ready=%b%b, want %b%b", i, req0_ready, req1_ready,
                 ~g, g);
      end
      seen[i] = req1_ready;
      if (g) sb.push_back({1'b1, 32'h00FF_0000});
      else   sb.push_back({1'b0, 32'hFFFF_FFFF});
      exp_last = g;
      tick();
      tick();
      @(negedge clk);
      if (sb.size() == 0) e = '0; else e = sb.pop_front();
      n_tests++;
      if ((e.owner ? rsp1_valid : rsp0_valid) !== 1'b1 ||
          (e.owner ? rsp0_valid : rsp1_valid) !== 1'b0 || rsp0_result !== e.res) begin
        n_fail++;
        $display("FAIL rr_resp[%0d]: got valid=%b%b r=%h, want owner=%0d %h", i, rsp0_valid,
                 rsp1_valid, rsp0_result, e.owner, e.res);
      end
      tick();
    end
    clear_inputs();
    n_tests++;
`ifdef YSYX_25040101_ALU_ARB_FIXED_PRIO_EN
    if (seen !== 3'b000) begin
`else
    if (seen !== 3'b010) begin
`endif
      n_fail++;
      $display("FAIL rr_sequence: got req1 grants=%b", seen);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic g;
    req0_valid = 1'b1; req0_op = 2'b00; req0_srca = 32'd100; req0_srcb = 32'd23;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got ready=%b%b, want 10", req0_ready, req1_ready);
    end
    sb.push_back({1'b0, ref_alu(req0_op, req0_srca, req0_srcb)});
    exp_last = 1'b0;
    tick();
    req0_srca = $urandom(); req1_valid = 1'b1; req1_srca = 32'h9; req1_srcb = 32'h3;
    tick();
    if (sb.size() == 0) e = '0; else e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) rsp0_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_result !== e.res ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b%b r0=%h ready=%b%b, want 10 %h 00", i,
                 rsp0_valid, rsp1_valid, rsp0_result, req0_ready, req1_ready, e.res);
      end
      tick();
    end
    @(negedge clk);
    g = tie_grant(exp_last);
    n_tests++;
    if (rsp0_valid !== 1'b0 || req0_ready !== ~g || req1_ready !== g) begin
      n_fail++;
      $display("FAIL bp_idle: got valid0=%b ready=%b%b, want 0 %b%b", rsp0_valid, req0_ready,
               req1_ready, ~g, g);
    end
    // Withdraw before the edge so no accept happens
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_in_exec();
    logic g;
    logic saw_valid;
    req0_valid = 1'b1; req0_op = 2'b00; req0_srca = 32'h11; req0_srcb = 32'h22;
    req1_valid = 1'b1; req1_op = 2'b01; req1_srca = 32'h33; req1_srcb = 32'h44;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    g = tie_grant(exp_last);
    n_tests++;
    if (req0_ready !== ~g || req1_ready !== g) begin
      n_fail++;
      $display("FAIL rx_accept: got ready=%b%b, want %b%b", req0_ready, req1_ready, ~g, g);
    end
    sb.push_back(g ? {1'b1, 32'hFFFF_FFEF} : {1'b0, 32'h0000_0033});
    tick();
    // Now in EXEC: abandon the operation
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    exp_last = 1'b1;
    @(negedge clk);
    n_tests++;
    if (alu_srca !== '0 || alu_srcb !== '0 || alu_ctrl !== 2'b00) begin
      n_fail++;
      $display("FAIL rx_alu_zero: got srca=%h srcb=%h ctrl=%b, want 0", alu_srca, alu_srcb,
               alu_ctrl);
    end
    saw_valid = rsp0_valid | rsp1_valid;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      saw_valid = saw_valid | rsp0_valid | rsp1_valid;
    end
    n_tests++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_no_rsp: got a response valid=%b, want none", saw_valid);
    end
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_fresh_tie: got ready=%b%b, want 10", req0_ready, req1_ready);
    end
    sb.push_back({1'b0, ref_alu(req0_op, req0_srca, req0_srcb)});
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (sb.size() == 0 || rsp0_valid !== 1'b1 || rsp0_result !== sb[0].res) begin
      n_fail++;
      $display("FAIL rx_fresh_resp: got valid=%b r0=%h, want 1 00000033", rsp0_valid,
               rsp0_result);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    tick();
    clear_inputs();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_last = 1'b1;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_add_wrap();
    test_sub_then_next();
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_25040101_alu_arb.md
YSYX_25040101_ALU_ARB -- requirements
Module: ysyx_25040101_alu_arb

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: operand and result width.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have, for N in {0,1}, port reqN_valid_i, input, 1 bit: requester N has an operation pending.
REQ-005 SHALL have port reqN_ready_o, output, 1 bit: the operation from requester N is accepted this cycle.
REQ-006 SHALL have port reqN_op_i, input, 2 bits: operation select; 00 add, 01 sub, 10 or, 11 and.
REQ-007 SHALL have ports reqN_srca_i and reqN_srcb_i, input, DATA_LEN bits each: operands A and B.
REQ-008 SHALL have port rspN_valid_o, output, 1 bit: a result is available for requester N.
REQ-009 SHALL have port rspN_ready_i, input, 1 bit: requester N takes the result this cycle.
REQ-010 SHALL have port rspN_result_o, output, DATA_LEN bits: the result for requester N.
REQ-011 SHALL have ports alu_srca_o and alu_srcb_o, output, DATA_LEN bits each: operands driven to the shared ALU.
REQ-012 SHALL have port alu_ctrl_o, output, 2 bits: operation select driven to the shared ALU.
REQ-013 SHALL have port alu_result_i, input, DATA_LEN bits: combinational result returned by the shared ALU.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-015 SHALL hold reqN_ready_o low outside IDLE; in IDLE it SHALL be high only for the granted requester, and only when that requester's valid is high.
REQ-016 A handshake SHALL capture the op, both operands and the owner id into registers, and SHALL move the FSM IDLE->EXEC.
REQ-017 SHALL drive alu_srca_o, alu_srcb_o and alu_ctrl_o from these registers at all times.
REQ-018 SHALL register alu_result_i at the end of the EXEC cycle; transition EXEC->RESP is unconditional.
REQ-019 In RESP, SHALL assert only the owner's rspN_valid_o; the non-owner's valid SHALL be 0.
REQ-020 SHALL drive both rspN_result_o from the result register, held stable until handshake.
REQ-021 On owner rspN_valid_o and rspN_ready_i, SHALL go RESP->IDLE; no new request is accepted in that cycle.
REQ-022 Latency SHALL be: accept at edge k, rsp valid from edge k+2; minimum 3 cycles per operation.
REQ-023 Grant with a single requester valid SHALL go to that requester.
REQ-024 Grant with both valid SHALL go to the requester not in last_grant (round robin); last_grant SHALL update only on an accept handshake.
REQ-025 Requesters SHALL hold valid and payload stable until ready; the arbiter SHALL not depend on payload outside the handshake cycle.
REQ-026 Results SHALL pass through unmodified: DATA_LEN-bit wrap-around, no carry or overflow reporting.
REQ-027 rspN_ready_i asserted while rspN_valid_o is low SHALL be ignored.

Reset
REQ-028 rst_i high at an edge SHALL set: FSM IDLE; operand, op, result and owner registers 0; last_grant 1 (req0 wins first tie).
REQ-029 Therefore after reset: alu_*_o = 0 and rspN_valid_o = 0; reqN_ready_o then follows the IDLE grant rules, so it is 0 unless requests are pending.
REQ-030 Reset in EXEC or RESP SHALL abandon the operation, with no response ever issued for it.
REQ-031 rst_i SHALL take priority over any simultaneous handshake.

Configuration
REQ-032 With macro YSYX_25040101_ALU_ARB_FIXED_PRIO_EN defined, req0 SHALL always win ties and last_grant SHALL be unused.
REQ-033 With the macro undefined, round robin per REQ-024 SHALL apply.

Verification
REQ-034 req0 add 0x7FFFFFFF+0x00000001, rsp0_ready=1 -> rsp0_result=0x80000000 two cycles after accept; rsp1_valid stays 0.
REQ-035 req1 sub 0x00000005-0x00000007 -> rsp1_result=0xFFFFFFFE; next op on either requester is accepted no earlier than the cycle after the response handshake.
REQ-036 Both valid continuously (req0 or 0xF0F0F0F0|0x0F0F0F0F, req1 and 0xFFFF0000&0x00FFFF00), round robin -> grants alternate req0, req1, req0; results 0xFFFFFFFF and 0x00FF0000. With the macro defined -> req0 is granted every time.
REQ-037 rsp0_ready held low for 4 cycles in RESP -> rsp0_valid and rsp0_result stable for all 4 cycles, both reqN_ready_o = 0; return to IDLE on the cycle after rsp0_ready rises.
REQ-038 rst_i pulsed during EXEC -> next cycle IDLE, no rsp valid ever seen for that op, alu_*_o = 0, then a fresh tie grants req0.
